// File: rtl/sparse_rle_encoder.sv
// Zero-run-length encoder: dense element stream -> {done, value, skip} SRAM entries.
// Optional statistics outputs (nnz_count_o, vec_count_o) are built when SPARSE_RLE_ENCODER_STATS_EN is defined.
package sparse_mac_pkg;
  localparam int VALUE_W = 8;
  localparam int SKIP_W  = 4;

  typedef struct packed {
    logic               done;
    logic [VALUE_W-1:0] value;
    logic [SKIP_W-1:0]  skip;
  } sram_data_t;
endpackage

module sparse_rle_encoder
  import sparse_mac_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               mac_clk,
  input  logic               mac_rst,
  input  logic               dense_valid_i,
  output logic               dense_ready_o,
  input  logic [VALUE_W-1:0] dense_data_i,
  input  logic               dense_last_i,
  output logic               sram_valid_o,
  input  logic               sram_ready_i,
  output sram_data_t         sram_data_o
`ifdef SPARSE_RLE_ENCODER_STATS_EN
  ,
  output logic [CNT_W-1:0]   nnz_count_o,
  output logic [CNT_W-1:0]   vec_count_o
`endif
);

  typedef enum logic [1:0] {
    STREAM    = 2'd0,
    DONE_LOAD = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  localparam logic [SKIP_W-1:0] SKIP_MAX = {SKIP_W{1'b1}};
  localparam logic [SKIP_W-1:0] ZC_ONE   = {{(SKIP_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  logic [SKIP_W-1:0] zc;
  logic [SKIP_W-1:0] zc_next;
  logic              alive;
  logic              out_free;
  logic              drain;
  logic              accept;
  logic              nonzero;
  logic              load;
  logic              load_nz;
  sram_data_t        load_data;

  assign drain    = sram_valid_o && sram_ready_i;
  assign out_free = !sram_valid_o || sram_ready_i;
  assign nonzero  = (dense_data_i != {VALUE_W{1'b0}});
  // alive keeps ready low until the first clock edge after reset release
  assign dense_ready_o = alive && (state == STREAM) && out_free;
  assign accept   = dense_valid_i && dense_ready_o;

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      state <= STREAM;
      zc    <= {SKIP_W{1'b0}};
      alive <= 1'b0;
    end else begin
      state <= state_next;
      zc    <= zc_next;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    zc_next    = zc;
    case (state)
      STREAM: begin
        if (accept) begin
          if (dense_last_i || nonzero || (zc == SKIP_MAX)) zc_next = {SKIP_W{1'b0}};
          else zc_next = zc + ZC_ONE;
          if (dense_last_i) state_next = DONE_LOAD;
          else state_next = STREAM;
        end else begin
          zc_next = zc;
        end
      end
      DONE_LOAD: begin
        if (out_free) state_next = DONE_WAIT;
        else state_next = DONE_LOAD;
      end
      DONE_WAIT: begin
        if (drain) state_next = STREAM;
        else state_next = DONE_WAIT;
      end
      default: state_next = STREAM;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    load_nz   = 1'b0;
    load_data = '0;
    case (state)
      STREAM: begin
        if (accept && nonzero) begin
          load            = 1'b1;
          load_nz         = 1'b1;
          load_data.value = dense_data_i;
          load_data.skip  = zc;
        end else if (accept && !dense_last_i && (zc == SKIP_MAX)) begin
          // saturation filler: value 0 advances the consumer by SKIP_MAX+1
          load           = 1'b1;
          load_data.skip = SKIP_MAX;
        end else begin
          load = 1'b0;
        end
      end
      DONE_LOAD: begin
        load           = out_free;
        load_data.done = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      sram_valid_o <= 1'b0;
      sram_data_o  <= '0;
    end else if (load) begin
      sram_valid_o <= 1'b1;
      sram_data_o  <= load_data;
    end else if (drain) begin
      sram_valid_o <= 1'b0;
    end else begin
      sram_valid_o <= sram_valid_o;
    end
  end

`ifdef SPARSE_RLE_ENCODER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] nnz_run;

  // nnz_run is published and restarted when the done token handshakes
  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      nnz_run     <= {CNT_W{1'b0}};
      nnz_count_o <= {CNT_W{1'b0}};
      vec_count_o <= {CNT_W{1'b0}};
    end else if ((state == DONE_WAIT) && drain) begin
      nnz_count_o <= nnz_run;
      nnz_run     <= {CNT_W{1'b0}};
      vec_count_o <= vec_count_o + CNT_ONE;
    end else if (load_nz) begin
      nnz_run <= nnz_run + CNT_ONE;
    end else begin
      nnz_run <= nnz_run;
    end
  end
`endif

endmodule
